// File: rtl/reorder_retire_ctrl_pkg.sv
// Shared definitions for the reorder/retire controller: head status encodings,
// FSM state type and default sizing of the tag space.
package reorder_retire_ctrl_pkg;

    localparam logic [1:0] ST_PENDING  = 2'b00;
    localparam logic [1:0] ST_REJECTED = 2'b01;
    localparam logic [1:0] ST_ACCEPTED = 2'b11;

    localparam int DEFAULT_TAG_WIDTH            = 6;
    localparam int DEFAULT_CIRCULAR_BUFFER_SIZE = 50;

    typedef enum logic {
        WAIT  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // A head entry is resolved once the status table has a verdict for it;
    // the unused encoding 2'b10 is deliberately treated as still pending.
    function automatic logic status_resolved(input logic [1:0] status);
        logic resolved;
        case (status)
            ST_PENDING:  resolved = 1'b0;
            ST_REJECTED: resolved = 1'b1;
            ST_ACCEPTED: resolved = 1'b1;
            default:     resolved = 1'b0;
        endcase
        return resolved;
    endfunction

endpackage

// File: rtl/reorder_retire_ctrl_tag_wrap_counter.sv
// Modulo-SIZE tag pointer with an increment enable; used for both the head
// (retire side) and the tail (allocation side) of the circular buffer.
module tag_wrap_counter #(
    parameter int WIDTH = 6,
    parameter int SIZE  = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(SIZE - 1);

    // Advance the pointer on enable, wrapping from the last tag back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/reorder_retire_ctrl.sv
// Reorder/retire controller: hands out reorder tags to packets entering the
// circular buffer and retires them strictly in tag order, forwarding accepted
// packets and dropping rejected ones. Retires at most one packet every two
// cycles. Optional macro REORDER_PENDING_TIMEOUT_EN adds a pending-head
// timeout that force-drops a stuck head and flags it on ret_timeout.
module reorder_retire_ctrl
    import reorder_retire_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH            = DEFAULT_TAG_WIDTH,
    parameter int CIRCULAR_BUFFER_SIZE = DEFAULT_CIRCULAR_BUFFER_SIZE
`ifdef REORDER_PENDING_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES       = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    output logic [TAG_WIDTH-1:0] cb_reorder_tag,
    input  logic [1:0]           cb_rd_packet_status,
    output logic                 ret_valid,
    input  logic                 ret_ready,
    output logic [TAG_WIDTH-1:0] ret_tag,
    output logic                 ret_accept,
    output logic [TAG_WIDTH:0]   occupancy,
    output logic                 full,
    output logic                 empty
`ifdef REORDER_PENDING_TIMEOUT_EN
    ,
    output logic                 ret_timeout
`endif
);

    logic [TAG_WIDTH-1:0] head;
    logic [TAG_WIDTH-1:0] tail;
    logic                 alloc_fire;
    logic                 ret_fire;
    logic                 head_resolved;
    state_t               state;

`ifdef REORDER_PENDING_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] pend_cnt;
`endif

    assign full           = (occupancy == (TAG_WIDTH + 1)'(CIRCULAR_BUFFER_SIZE));
    assign empty          = (occupancy == '0);
    assign alloc_ready    = !full;
    assign alloc_fire     = alloc_valid && alloc_ready;
    assign ret_fire       = ret_valid && ret_ready;
    assign alloc_tag      = tail;
    assign cb_reorder_tag = head;
    assign head_resolved  = status_resolved(cb_rd_packet_status);

    tag_wrap_counter #(
        .WIDTH (TAG_WIDTH),
        .SIZE  (CIRCULAR_BUFFER_SIZE)
    ) u_tail (
        .clk   (clk),
        .rst   (rst),
        .inc   (alloc_fire),
        .value (tail)
    );

    tag_wrap_counter #(
        .WIDTH (TAG_WIDTH),
        .SIZE  (CIRCULAR_BUFFER_SIZE)
    ) u_head (
        .clk   (clk),
        .rst   (rst),
        .inc   (ret_fire),
        .value (head)
    );

    // Track live tags; a simultaneous allocate and retire cancel out, and a
    // freed slot only shows up in alloc_ready on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else begin
            case ({alloc_fire, ret_fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Retire FSM: latch the head verdict in WAIT, then hold it stable in OFFER
    // until egress takes it, so later status-table changes cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= WAIT;
            ret_valid  <= 1'b0;
            ret_tag    <= '0;
            ret_accept <= 1'b0;
`ifdef REORDER_PENDING_TIMEOUT_EN
            ret_timeout <= 1'b0;
            pend_cnt    <= '0;
`endif
        end else begin
            case (state)
                WAIT: begin
                    if (!empty && head_resolved) begin
                        state      <= OFFER;
                        ret_valid  <= 1'b1;
                        ret_tag    <= head;
                        ret_accept <= (cb_rd_packet_status == ST_ACCEPTED);
`ifdef REORDER_PENDING_TIMEOUT_EN
                        ret_timeout <= 1'b0;
                        pend_cnt    <= '0;
                    end else if (!empty) begin
                        if (pend_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state       <= OFFER;
                            ret_valid   <= 1'b1;
                            ret_tag     <= head;
                            ret_accept  <= 1'b0;
                            ret_timeout <= 1'b1;
                            pend_cnt    <= '0;
                        end else begin
                            pend_cnt <= pend_cnt + 1'b1;
                        end
                    end else begin
                        pend_cnt <= '0;
`endif
                    end
                end
                OFFER: begin
                    if (ret_ready) begin
                        state     <= WAIT;
                        ret_valid <= 1'b0;
`ifdef REORDER_PENDING_TIMEOUT_EN
                        ret_timeout <= 1'b0;
                        pend_cnt    <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_retire_ctrl.sv
// Testbench for reorder_retire_ctrl: table-driven allocate/retire vectors
// followed by hand-written sequences for fill/wrap, same-cycle traffic,
// async reset during OFFER and (with REORDER_PENDING_TIMEOUT_EN) the timeout.
module tb_reorder_retire_ctrl;

    localparam int TW = 6;
    localparam int SZ = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic [TW-1:0] cb_reorder_tag;
    logic [1:0]    cb_rd_packet_status;
    logic          ret_valid;
    logic          ret_ready;
    logic [TW-1:0] ret_tag;
    logic          ret_accept;
    logic [TW:0]   occupancy;
    logic          full;
    logic          empty;
`ifdef REORDER_PENDING_TIMEOUT_EN
    logic          ret_timeout;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          av;
        logic [1:0]    st;
        logic          rr;
        logic [TW-1:0] e_atag;
        logic [TW:0]   e_occ;
        logic          e_rv;
        logic [TW-1:0] e_rtag;
        logic          e_racc;
        logic [TW-1:0] e_head;
        logic          e_empty;
    } vec_t;

    vec_t vecs[19];

    always #5 clk = ~clk;

    reorder_retire_ctrl #(
        .TAG_WIDTH            (TW),
        .CIRCULAR_BUFFER_SIZE (SZ)
`ifdef REORDER_PENDING_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES       (8)
`endif
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_valid         (alloc_valid),
        .alloc_ready         (alloc_ready),
        .alloc_tag           (alloc_tag),
        .cb_reorder_tag      (cb_reorder_tag),
        .cb_rd_packet_status (cb_rd_packet_status),
        .ret_valid           (ret_valid),
        .ret_ready           (ret_ready),
        .ret_tag             (ret_tag),
        .ret_accept          (ret_accept),
        .occupancy           (occupancy),
        .full                (full),
        .empty               (empty)
`ifdef REORDER_PENDING_TIMEOUT_EN
        ,
        .ret_timeout         (ret_timeout)
`endif
    );

    function automatic vec_t mk(input int av, input int st, input int rr,
                                input int atag, input int occ, input int rv,
                                input int rtag, input int racc, input int head,
                                input int emp);
        vec_t v;
        v.av      = 1'(av);
        v.st      = 2'(st);
        v.rr      = 1'(rr);
        v.e_atag  = TW'(atag);
        v.e_occ   = (TW + 1)'(occ);
        v.e_rv    = 1'(rv);
        v.e_rtag  = TW'(rtag);
        v.e_racc  = 1'(racc);
        v.e_head  = TW'(head);
        v.e_empty = 1'(emp);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic av, input logic [1:0] st, input logic rr);
        alloc_valid         = av;
        cb_rd_packet_status = st;
        ret_ready           = rr;
        #1;
    endtask

    task automatic doReset();
        alloc_valid         = 1'b0;
        cb_rd_packet_status = 2'b00;
        ret_ready           = 1'b0;
        rst                 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //             av st rr atag occ rv rtag racc head empty
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[1]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 2, 2, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 3, 0, 3, 3, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 3, 1, 3, 3, 1, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 3, 2, 0, 0, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0, 3, 2, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 1, 0, 3, 2, 0, 0, 0, 1, 0);
        vecs[8]  = mk(0, 1, 1, 3, 2, 1, 1, 0, 1, 0);
        vecs[9]  = mk(0, 3, 0, 3, 1, 0, 0, 0, 2, 0);
        vecs[10] = mk(0, 3, 1, 3, 1, 1, 2, 1, 2, 0);
        vecs[11] = mk(0, 3, 0, 3, 0, 0, 0, 0, 3, 1);
        vecs[12] = mk(1, 2, 0, 3, 0, 0, 0, 0, 3, 1);
        vecs[13] = mk(0, 2, 0, 4, 1, 0, 0, 0, 3, 0);
        vecs[14] = mk(0, 2, 0, 4, 1, 0, 0, 0, 3, 0);
        vecs[15] = mk(0, 3, 0, 4, 1, 0, 0, 0, 3, 0);
        vecs[16] = mk(0, 0, 0, 4, 1, 1, 3, 1, 3, 0);
        vecs[17] = mk(0, 1, 1, 4, 1, 1, 3, 1, 3, 0);
        vecs[18] = mk(0, 0, 0, 4, 0, 0, 0, 0, 4, 1);

        doReset();
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("reset_occupancy", 16'(occupancy), 16'd0);
        checkOutput("reset_empty", 16'(empty), 16'd1);
        checkOutput("reset_full", 16'(full), 16'd0);
        checkOutput("reset_alloc_ready", 16'(alloc_ready), 16'd1);
        checkOutput("reset_ret_valid", 16'(ret_valid), 16'd0);
        checkOutput("reset_ret_tag", 16'(ret_tag), 16'd0);
        checkOutput("reset_ret_accept", 16'(ret_accept), 16'd0);
        @(negedge clk);

        // In-order allocate/retire vectors
        for (int v = 0; v < 19; v++) begin
            applyStimulus(vecs[v].av, vecs[v].st, vecs[v].rr);
            checkOutput($sformatf("vec%0d_alloc_tag", v), 16'(alloc_tag), 16'(vecs[v].e_atag));
            checkOutput($sformatf("vec%0d_occupancy", v), 16'(occupancy), 16'(vecs[v].e_occ));
            checkOutput($sformatf("vec%0d_ret_valid", v), 16'(ret_valid), 16'(vecs[v].e_rv));
            checkOutput($sformatf("vec%0d_head", v), 16'(cb_reorder_tag), 16'(vecs[v].e_head));
            checkOutput($sformatf("vec%0d_empty", v), 16'(empty), 16'(vecs[v].e_empty));
            if (vecs[v].e_rv) begin
                checkOutput($sformatf("vec%0d_ret_tag", v), 16'(ret_tag), 16'(vecs[v].e_rtag));
                checkOutput($sformatf("vec%0d_ret_accept", v), 16'(ret_accept), 16'(vecs[v].e_racc));
            end
            @(negedge clk);
        end

        // Fill to full, ignored extra alloc, wrap to tag 0 after one retire
        doReset();
        for (int i = 0; i < SZ; i++) begin
            applyStimulus(1'b1, 2'b00, 1'b0);
            checkOutput($sformatf("fill_tag%0d", i), 16'(alloc_tag), 16'(i));
            @(negedge clk);
        end
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("full_flag", 16'(full), 16'd1);
        checkOutput("full_alloc_ready", 16'(alloc_ready), 16'd0);
        checkOutput("full_occupancy", 16'(occupancy), 16'd50);
        @(negedge clk);
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("full_tail_held", 16'(alloc_tag), 16'd0);
        checkOutput("full_occ_held", 16'(occupancy), 16'd50);
        @(negedge clk);
        applyStimulus(1'b1, 2'b11, 1'b1);
        checkOutput("full_retire_valid", 16'(ret_valid), 16'd1);
        checkOutput("full_retire_tag", 16'(ret_tag), 16'd0);
        checkOutput("full_ready_during_retire", 16'(alloc_ready), 16'd0);
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("freed_alloc_ready", 16'(alloc_ready), 16'd1);
        checkOutput("freed_alloc_tag", 16'(alloc_tag), 16'd0);
        checkOutput("freed_occupancy", 16'(occupancy), 16'd49);
        checkOutput("freed_head", 16'(cb_reorder_tag), 16'd1);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("refill_full", 16'(full), 16'd1);
        checkOutput("refill_tail", 16'(alloc_tag), 16'd1);

        // Stall in OFFER, then simultaneous allocate and retire at occupancy 10
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'b00, 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 2'b11, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, (k % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
            checkOutput($sformatf("stall%0d_valid", k), 16'(ret_valid), 16'd1);
            checkOutput($sformatf("stall%0d_tag", k), 16'(ret_tag), 16'd0);
            checkOutput($sformatf("stall%0d_accept", k), 16'(ret_accept), 16'd1);
            @(negedge clk);
        end
        applyStimulus(1'b1, 2'b00, 1'b1);
        checkOutput("both_pre_occ", 16'(occupancy), 16'd10);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("both_post_occ", 16'(occupancy), 16'd10);
        checkOutput("both_post_head", 16'(cb_reorder_tag), 16'd1);
        checkOutput("both_post_tail", 16'(alloc_tag), 16'd11);
        checkOutput("both_post_valid", 16'(ret_valid), 16'd0);

        // Asynchronous reset while offering
        applyStimulus(1'b0, 2'b01, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 2'b01, 1'b0);
        checkOutput("offer_before_rst_valid", 16'(ret_valid), 16'd1);
        checkOutput("offer_before_rst_tag", 16'(ret_tag), 16'd1);
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", 16'(ret_valid), 16'd0);
        checkOutput("async_rst_tag", 16'(ret_tag), 16'd0);
        checkOutput("async_rst_occ", 16'(occupancy), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 2'b11, 1'b0);
        checkOutput("post_rst_head", 16'(cb_reorder_tag), 16'd0);
        checkOutput("post_rst_empty", 16'(empty), 16'd1);
        checkOutput("post_rst_tail", 16'(alloc_tag), 16'd0);
        @(negedge clk);
        applyStimulus(1'b0, 2'b11, 1'b0);
        checkOutput("empty_ignores_status", 16'(ret_valid), 16'd0);
        @(negedge clk);

`ifdef REORDER_PENDING_TIMEOUT_EN
        // Pending head times out after 8 cycles and is force-dropped
        applyStimulus(1'b1, 2'b00, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0);
            checkOutput($sformatf("pending%0d_valid", i), 16'(ret_valid), 16'd0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("timeout_valid", 16'(ret_valid), 16'd1);
        checkOutput("timeout_accept", 16'(ret_accept), 16'd0);
        checkOutput("timeout_flag", 16'(ret_timeout), 16'd1);
        checkOutput("timeout_tag", 16'(ret_tag), 16'd0);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("timeout_flag_clear", 16'(ret_timeout), 16'd0);
        checkOutput("timeout_occ", 16'(occupancy), 16'd0);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_retire_ctrl.md
Name: reorder_retire_ctrl

Overview:
- Sequences the per-packet status table: allocates reorder tags to packets entering the circular buffer and owns the head pointer (`cb_reorder_tag`).
- Reads each head entry's 2-bit status and retires packets strictly in tag order: forwards accepted packets and drops rejected ones.
- Sits between the circular buffer, the status table and the egress path; BPF cores are unaffected.

Parameters:
- TAG_WIDTH, 6, width of reorder tag.
- CIRCULAR_BUFFER_SIZE, 50, number of tags in use (0..SIZE-1); must be ≤ 2**TAG_WIDTH.
- TIMEOUT_CYCLES, 1024, pending-head timeout; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- alloc_valid  in  1  new packet requests a tag
- alloc_ready  out  1  tag available (= !full)
- alloc_tag  out  TAG_WIDTH  tag granted on alloc handshake (= tail)
- cb_reorder_tag  out  TAG_WIDTH  head tag, drives status-table read and buffer read
- cb_rd_packet_status  in  2  status of head: 00 pending, 01 rejected, 11 accepted
- ret_valid  out  1  head packet ready to retire
- ret_ready  in  1  egress/buffer accepts retire
- ret_tag  out  TAG_WIDTH  tag being retired
- ret_accept  out  1  1 = forward, 0 = drop
- occupancy  out  TAG_WIDTH+1  allocated, unretired tags
- full  out  1  occupancy == CIRCULAR_BUFFER_SIZE
- empty  out  1  occupancy == 0

Behaviour:
- Reset (rst=0, async): head=0, tail=0, occupancy=0, state=WAIT, ret_valid=0, ret_accept=0, ret_tag=0; so full=0, empty=1, alloc_ready=1. Reset mid-operation discards all in-flight tags; no ret handshake completes while reset is asserted.
- Allocation:
  - Handshake is alloc_valid & alloc_ready. alloc_tag is combinational from tail.
  - On handshake, tail increments; it wraps from SIZE-1 to 0.
- Head pointer: increments with the same wrap rule, only on a ret handshake.
- Occupancy: registered; +1 on alloc only, -1 on retire only, unchanged when both occur in the same cycle.
- Freed slot timing: a slot freed by retire becomes allocatable no earlier than the next cycle, because occupancy is registered. This leaves the status table one cycle to clear the old head entry.
- FSM:
  - WAIT: if !empty and status[0]==1, latch ret_tag=head and ret_accept=status[1], then go to OFFER next cycle. Pending (00) or empty: stay in WAIT. If empty, status is ignored even when nonzero.
  - OFFER: ret_valid=1. ret_tag and ret_accept are held stable until ret_ready. On handshake: head++, occupancy--, ret_valid=0 next cycle, go to WAIT.
- Throughput: at most one retire per 2 cycles. Latency from status becoming valid to ret_valid is 1 cycle.
- Full: alloc_ready=0; alloc_valid is ignored and tail is held.
- Status 10 is illegal; treat it as pending.
- Status changes during OFFER are ignored, because the values are latched.

Optional Feature:
- Macro: REORDER_PENDING_TIMEOUT_EN
- With the macro:
  - A counter runs while in WAIT with !empty and the head pending. It clears on any head advance or when the head is non-pending.
  - When it reaches TIMEOUT_CYCLES-1, the FSM enters OFFER with ret_accept=0 (forced drop) and raises an extra output port, ret_timeout (1 bit), for that retire. ret_timeout resets to 0.
- Without the macro: no counter and no ret_timeout port; a pending head blocks indefinitely.

Decomposition:
- Shared package:
  - Status encodings: ST_PENDING=2'b00, ST_REJECTED=2'b01, ST_ACCEPTED=2'b11.
  - FSM state enum {WAIT, OFFER}.
  - Default TAG_WIDTH and CIRCULAR_BUFFER_SIZE constants.
- One natural sub-module, tag_wrap_counter: a modulo-SIZE pointer with an increment enable, instantiated for head and tail.

Test Plan:
- Reset, then 3 allocs → alloc_tag 0,1,2; occupancy=3. Status of tag 0 set to 11 → ret_valid one cycle later with ret_tag=0, ret_accept=1; with ret_ready=1, head becomes 1.
- Head 1 pending, tag 2 accepted → no ret_valid. Tag 1 then set to 01 → tag 1 retired with ret_accept=0, then tag 2 retired with ret_accept=1, in order.
- 50 allocs → full=1, alloc_ready=0; a 51st alloc_valid is ignored. Retire tag 0 → next alloc is granted tag 0 (wrap), no earlier than 1 cycle after the retire.
- Allocate and retire in the same cycle at occupancy 10 → occupancy stays 10; ret_ready held low for 5 cycles → ret_tag and ret_accept stay stable.
- rst asserted in OFFER → ret_valid drops immediately (async); after release head=0, empty=1.
- With REORDER_PENDING_TIMEOUT_EN and TIMEOUT_CYCLES=8: head pending for 8 cycles → ret_valid with ret_accept=0 and ret_timeout=1.
